pcs_receive: RTL

PCS_RECEIVE -- requirements
Module: pcs_receive

---
 rtl/pcs_receive.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pcs_receive.sv
// pcs_receive: 1000BASE-X PCS receive path, 8b/10b decode plus receive state machine.
// Optional build macro RX_DISP_CHECK_EN rejects code-groups that only exist in the other disparity column.
module pcs_receive #(
  parameter logic [7:0] SOP_DATA = 8'h55
) (
  input  logic       gtx_clk,
  input  logic       mr_main_reset,
  input  logic [9:0] rx_code_group,
  input  logic       sync_status,
  output logic [7:0] RXD,
  output logic       RX_DV,
  output logic       RX_ER,
  output logic       rx_even,
  output logic       rx_disparity,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    WAIT_FOR_K = 3'd0,
    RX_K       = 3'd1,
    IDLE_D     = 3'd2,
    RECEIVE    = 3'd3,
    TRI_RRI    = 3'd4
  } state_t;

  // Symbols are {K, HGF, EDCBA}.
  localparam logic [8:0] SYM_K28_5 = {1'b1, 8'hBC};
  localparam logic [8:0] SYM_K27_7 = {1'b1, 8'hFB};
  localparam logic [8:0] SYM_K29_7 = {1'b1, 8'hFD};
  localparam logic [8:0] SYM_K23_7 = {1'b1, 8'hF7};
  localparam logic [8:0] SYM_D16_2 = {1'b0, 8'h50};
  localparam logic [8:0] SYM_D5_6  = {1'b0, 8'hC5};

  function automatic logic [5:0] d6_minus(input logic [4:0] x);
    case (x)
      5'd0:  d6_minus = 6'b100111;
      5'd1:  d6_minus = 6'b011101;
      5'd2:  d6_minus = 6'b101101;
      5'd3:  d6_minus = 6'b110001;
      5'd4:  d6_minus = 6'b110101;
      5'd5:  d6_minus = 6'b101001;
      5'd6:  d6_minus = 6'b011001;
      5'd7:  d6_minus = 6'b111000;
      5'd8:  d6_minus = 6'b111001;
      5'd9:  d6_minus = 6'b100101;
      5'd10: d6_minus = 6'b010101;
      5'd11: d6_minus = 6'b110100;
      5'd12: d6_minus = 6'b001101;
      5'd13: d6_minus = 6'b101100;
      5'd14: d6_minus = 6'b011100;
      5'd15: d6_minus = 6'b010111;
      5'd16: d6_minus = 6'b011011;
      5'd17: d6_minus = 6'b100011;
      5'd18: d6_minus = 6'b010011;
      5'd19: d6_minus = 6'b110010;
      5'd20: d6_minus = 6'b001011;
      5'd21: d6_minus = 6'b101010;
      5'd22: d6_minus = 6'b011010;
      5'd23: d6_minus = 6'b111010;
      5'd24: d6_minus = 6'b110011;
      5'd25: d6_minus = 6'b100110;
      5'd26: d6_minus = 6'b010110;
      5'd27: d6_minus = 6'b110110;
      5'd28: d6_minus = 6'b001110;
      5'd29: d6_minus = 6'b101110;
      5'd30: d6_minus = 6'b011110;
      default: d6_minus = 6'b101011;
    endcase
  endfunction

  // 6b sub-blocks that have a distinct RD+ form (the unbalanced ones plus D.7).
  function automatic logic flip6(input logic [4:0] x);
    case (x)
      5'd0, 5'd1, 5'd2, 5'd4, 5'd7, 5'd8, 5'd15, 5'd16,
      5'd23, 5'd24, 5'd27, 5'd29, 5'd30, 5'd31: flip6 = 1'b1;
      default: flip6 = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] d4_minus(input logic [2:0] y);
    case (y)
      3'd0: d4_minus = 4'b1011;
      3'd1: d4_minus = 4'b1001;
      3'd2: d4_minus = 4'b0101;
      3'd3: d4_minus = 4'b1100;
      3'd4: d4_minus = 4'b1101;
      3'd5: d4_minus = 4'b1010;
      3'd6: d4_minus = 4'b0110;
      default: d4_minus = 4'b1110;
    endcase
  endfunction

  function automatic logic flip4(input logic [2:0] y);
    flip4 = (y == 3'd0) || (y == 3'd3) || (y == 3'd4) || (y == 3'd7);
  endfunction

  function automatic logic [3:0] k4_minus(input logic [2:0] y);
    case (y)
      3'd0: k4_minus = 4'b1011;
      3'd1: k4_minus = 4'b0110;
      3'd2: k4_minus = 4'b1010;
      3'd3: k4_minus = 4'b1100;
      3'd4: k4_minus = 4'b1101;
      3'd5: k4_minus = 4'b0101;
      3'd6: k4_minus = 4'b1001;
      default: k4_minus = 4'b0111;
    endcase
  endfunction

  function automatic logic [9:0] encode(input logic [8:0] sym, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd6;
    logic       alt7;
    int         n6;
    x = sym[4:0];
    y = sym[7:5];
    if (sym[8] && x == 5'd28) c6 = rd ? 6'b110000 : 6'b001111;
    else if (rd && flip6(x))  c6 = ~d6_minus(x);
    else                      c6 = d6_minus(x);
    n6   = $countones(c6);
    rd6  = (n6 > 3) ? 1'b1 : ((n6 < 3) ? 1'b0 : rd);
    alt7 = rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
               : (x == 5'd17 || x == 5'd18 || x == 5'd20);
    if (sym[8])                  c4 = rd6 ? ~k4_minus(y) : k4_minus(y);
    else if (y == 3'd7 && alt7)  c4 = rd6 ? 4'b1000 : 4'b0111;
    else if (rd6 && flip4(y))    c4 = ~d4_minus(y);
    else                         c4 = d4_minus(y);
    encode = {c6, c4};
  endfunction

  logic [5:0] w_c6;
  logic [3:0] w_c4;
  logic [3:0] w_n4;
  logic       w_k28;
  logic [4:0] w_x;
  logic [2:0] w_y;
  logic       w_k;
  logic       w_found6;
  logic       w_found4;
  logic [8:0] w_sym;
  logic       w_ok_m;
  logic       w_ok_p;
  logic       w_valid;

  assign w_c6  = rx_code_group[9:4];
  assign w_c4  = rx_code_group[3:0];
  assign w_k28 = (w_c6 == 6'b001111) || (w_c6 == 6'b110000);
  // K28 fghj always follows an unbalanced 6b block; fold it back to the RD- table.
  assign w_n4  = (w_c6 == 6'b001111) ? ~w_c4 : w_c4;

  always_comb begin
    w_x      = 5'd28;
    w_found6 = w_k28;
    for (int i = 0; i < 32; i++) begin
      if (w_c6 == d6_minus(5'(i)) || (flip6(5'(i)) && w_c6 == ~d6_minus(5'(i)))) begin
        w_x      = 5'(i);
        w_found6 = 1'b1;
      end
    end
  end

  always_comb begin
    w_y      = 3'd0;
    w_found4 = 1'b0;
    w_k      = 1'b0;
    if (w_k28) begin
      w_k = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (w_n4 == k4_minus(3'(i))) begin
          w_y      = 3'(i);
          w_found4 = 1'b1;
        end
      end
    end else if (w_c4 == 4'b0111 || w_c4 == 4'b1000) begin
      w_y      = 3'd7;
      w_found4 = 1'b1;
      w_k      = (w_x == 5'd23) || (w_x == 5'd27) || (w_x == 5'd29) || (w_x == 5'd30);
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_c4 == d4_minus(3'(i)) || (flip4(3'(i)) && w_c4 == ~d4_minus(3'(i)))) begin
          w_y      = 3'(i);
          w_found4 = 1'b1;
        end
      end
    end
  end

  // The candidate symbol is genuine only if re-encoding it reproduces the input exactly.
  assign w_sym  = {w_k, w_y, w_x};
  assign w_ok_m = w_found6 && w_found4 && (encode(w_sym, 1'b0) == rx_code_group);
  assign w_ok_p = w_found6 && w_found4 && (encode(w_sym, 1'b1) == rx_code_group);

`ifdef RX_DISP_CHECK_EN
  assign w_valid = rx_disparity ? w_ok_p : w_ok_m;
`else
  assign w_valid = w_ok_m || w_ok_p;
`endif

  logic w_is_k285;
  logic w_is_sop;
  logic w_is_eop;
  logic w_is_car;
  logic w_is_idle_d;
  logic [3:0] w_ones;

  assign w_is_k285   = w_valid && (w_sym == SYM_K28_5);
  assign w_is_sop    = w_valid && (w_sym == SYM_K27_7);
  assign w_is_eop    = w_valid && (w_sym == SYM_K29_7);
  assign w_is_car    = w_valid && (w_sym == SYM_K23_7);
  assign w_is_idle_d = w_valid && (w_sym == SYM_D16_2 || w_sym == SYM_D5_6);
  assign w_ones      = 4'($countones(rx_code_group));

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] w_rxd_nxt;
  logic       w_dv_nxt;
  logic       w_er_nxt;
  logic       w_even_nxt;
  logic       w_disp_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_rxd_nxt   = 8'h00;
    w_dv_nxt    = 1'b0;
    w_er_nxt    = 1'b0;
    w_even_nxt  = ~rx_even;
    if (w_ones > 4'd5)      w_disp_nxt = 1'b1;
    else if (w_ones < 4'd5) w_disp_nxt = 1'b0;
    else                    w_disp_nxt = rx_disparity;
    if (!sync_status) begin
      w_state_nxt = WAIT_FOR_K;
    end else begin
      case (r_state)
        WAIT_FOR_K: begin
          if (w_is_k285) begin
            w_state_nxt = RX_K;
            w_even_nxt  = 1'b1;
          end
        end
        RX_K: begin
          w_state_nxt = w_is_idle_d ? IDLE_D : WAIT_FOR_K;
        end
        IDLE_D: begin
          if (w_is_k285) begin
            w_state_nxt = RX_K;
            w_even_nxt  = 1'b1;
          end else if (w_is_sop) begin
            w_state_nxt = RECEIVE;
            w_dv_nxt    = 1'b1;
            w_rxd_nxt   = SOP_DATA;
          end else begin
            w_state_nxt = WAIT_FOR_K;
          end
        end
        RECEIVE: begin
          if (w_is_k285) begin
            w_state_nxt = RX_K;
            w_er_nxt    = 1'b1;
            w_even_nxt  = 1'b1;
          end else if (w_is_eop) begin
            w_state_nxt = TRI_RRI;
          end else if (w_valid && !w_k) begin
            w_dv_nxt  = 1'b1;
            w_rxd_nxt = w_sym[7:0];
          end else begin
            w_dv_nxt = 1'b1;
            w_er_nxt = 1'b1;
          end
        end
        TRI_RRI: begin
          if (w_is_k285) begin
            w_state_nxt = RX_K;
            w_even_nxt  = 1'b1;
          end else if (!w_is_car) begin
            w_state_nxt = WAIT_FOR_K;
            w_er_nxt    = 1'b1;
          end
        end
        default: w_state_nxt = WAIT_FOR_K;
      endcase
    end
  end

  always_ff @(posedge gtx_clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      r_state      <= WAIT_FOR_K;
      RXD          <= 8'h00;
      RX_DV        <= 1'b0;
      RX_ER        <= 1'b0;
      rx_even      <= 1'b0;
      rx_disparity <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      RXD          <= w_rxd_nxt;
      RX_DV        <= w_dv_nxt;
      RX_ER        <= w_er_nxt;
      rx_even      <= w_even_nxt;
      rx_disparity <= w_disp_nxt;
    end
  end

  assign dbg_state = r_state;

endmodule
